// File: rtl/pd_pwr_seq_fsm_pkg.sv
// Shared types and constants for the per-domain power sequencer.
// Consumers: pd_pwr_seq_fsm_if, pd_pwr_seq_fsm, seq_delay_timer.
package pwr_ctrl_pkg;

  localparam int SEQ_DLY_W  = 4;  // step-to-step sequence delays
  localparam int DCDC_DLY_W = 8;  // supply on/off delays, also the timer width
  localparam int WAKE_SRC_N = 3;  // wakeup sources per domain

  typedef enum logic [3:0] {
    ST_ACTIVE   = 4'd0,
    ST_CG_SLEEP = 4'd1,
    ST_OFF_CLK  = 4'd2,
    ST_OFF_ISO  = 4'd3,
    ST_OFF_RET  = 4'd4,
    ST_OFF_RST  = 4'd5,
    ST_OFF      = 4'd6,
    ST_ON_DCDC  = 4'd7,
    ST_ON_RST   = 4'd8,
    ST_ON_RET   = 4'd9,
    ST_ON_ISO   = 4'd10
  } pwr_seq_state_t;

  // Zero-extend a 4-bit sequence delay to the timer width.
  function automatic logic [DCDC_DLY_W-1:0] seq_dly_ext(input logic [SEQ_DLY_W-1:0] d);
    return {{(DCDC_DLY_W-SEQ_DLY_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/pd_pwr_seq_fsm_if.sv
// Register-file and domain-control bundle for one power domain.
// master: register file / domain side, slave: the sequencer.
interface pd_pwr_seq_fsm_if;
  import pwr_ctrl_pkg::*;

  logic                  i_sleep_req;
  logic [WAKE_SRC_N-1:0] i_wakeup_en;
  logic [WAKE_SRC_N-1:0] i_wakeup_src;
  logic                  i_pwrgate_en;
  logic [SEQ_DLY_W-1:0]  i_pwr_on_seq_delay;
  logic [SEQ_DLY_W-1:0]  i_pwr_off_seq_delay;
  logic [DCDC_DLY_W-1:0] i_pwr_on_delay;
  logic [DCDC_DLY_W-1:0] i_pwr_off_delay;
  logic                  o_clk_en;
  logic                  o_iso;
  logic                  o_ret;
  logic                  o_rstn;
  logic                  o_dcdc_enable;
  logic                  o_d_status;
  pwr_seq_state_t        dbg_state;

  // Level-based control: inputs are register fields sampled every clock,
  // outputs are registered levels; there is no valid/ready handshake.
  modport master (
    output i_sleep_req, i_wakeup_en, i_wakeup_src, i_pwrgate_en,
           i_pwr_on_seq_delay, i_pwr_off_seq_delay, i_pwr_on_delay, i_pwr_off_delay,
    input  o_clk_en, o_iso, o_ret, o_rstn, o_dcdc_enable, o_d_status, dbg_state
  );

  modport slave (
    input  i_sleep_req, i_wakeup_en, i_wakeup_src, i_pwrgate_en,
           i_pwr_on_seq_delay, i_pwr_off_seq_delay, i_pwr_on_delay, i_pwr_off_delay,
    output o_clk_en, o_iso, o_ret, o_rstn, o_dcdc_enable, o_d_status, dbg_state
  );

endinterface

// File: rtl/pd_pwr_seq_fsm_timer.sv
// seq_delay_timer: 8-bit loadable down-counter for sequencer dwells.
// done is high max(value,1) cycles after the load cycle.
module seq_delay_timer
  import pwr_ctrl_pkg::*;
(
  input  logic                  i_aon_clk,
  input  logic                  i_soc_pwr_on_rst,
  input  logic                  load,
  input  logic [DCDC_DLY_W-1:0] value,
  output logic                  done
);

  logic [DCDC_DLY_W-1:0] cnt;

  // Load max(value,1), then count down to 1; zero is the idle value.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (value == '0) ? DCDC_DLY_W'(1) : value;
    end else if (cnt != '0) begin
      cnt <= cnt - DCDC_DLY_W'(1);
    end
  end

  assign done = (cnt == DCDC_DLY_W'(1));

endmodule

// File: rtl/pd_pwr_seq_fsm.sv
// Per-domain power sequencer: clock-gate or full power-gate sleep and
// the ordered clk/iso/ret/rst/dcdc off and on sequences.
// Build option PWR_SEQ_WAKE_SYNC_EN: 2-flop synchronizer on i_wakeup_src.
module pd_pwr_seq_fsm
  import pwr_ctrl_pkg::*;
(
  input logic             i_aon_clk,
  input logic             i_soc_pwr_on_rst,
  pd_pwr_seq_fsm_if.slave bus
);

  pwr_seq_state_t        state;
  logic                  wake_pend;
  logic                  wake_hit;
  logic [WAKE_SRC_N-1:0] wake_src;
  logic                  tmr_load;
  logic [DCDC_DLY_W-1:0] tmr_value;
  logic                  tmr_done;
  logic                  clk_en_q;
  logic                  iso_q;
  logic                  ret_q;
  logic                  rstn_q;
  logic                  dcdc_q;
  logic                  status_q;

`ifdef PWR_SEQ_WAKE_SYNC_EN
  logic [WAKE_SRC_N-1:0] sync_q1;
  logic [WAKE_SRC_N-1:0] sync_q2;

  // Two-flop synchronizer for asynchronous wakeup sources.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.i_wakeup_src;
      sync_q2 <= sync_q1;
    end
  end

  assign wake_src = sync_q2;
`else
  assign wake_src = bus.i_wakeup_src;
`endif

  assign wake_hit = |(wake_src & bus.i_wakeup_en);

  // Timer load on every transition into a dwell state; the delay field
  // is captured here so later register writes do not disturb the dwell.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      ST_ACTIVE: begin
        tmr_load  = bus.i_sleep_req && bus.i_pwrgate_en;
        tmr_value = seq_dly_ext(bus.i_pwr_off_seq_delay);
      end
      ST_OFF_CLK, ST_OFF_ISO: begin
        tmr_load  = tmr_done;
        tmr_value = seq_dly_ext(bus.i_pwr_off_seq_delay);
      end
      ST_OFF_RET: begin
        tmr_load  = tmr_done;
        tmr_value = bus.i_pwr_off_delay;
      end
      ST_OFF: begin
        tmr_load  = wake_pend;
        tmr_value = bus.i_pwr_on_delay;
      end
      ST_ON_DCDC, ST_ON_RST, ST_ON_RET: begin
        tmr_load  = tmr_done;
        tmr_value = seq_dly_ext(bus.i_pwr_on_seq_delay);
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = '0;
      end
    endcase
  end

  seq_delay_timer u_timer (
    .i_aon_clk        (i_aon_clk),
    .i_soc_pwr_on_rst (i_soc_pwr_on_rst),
    .load             (tmr_load),
    .value            (tmr_value),
    .done             (tmr_done)
  );

  // Sequencer state, wake-pending flag and registered domain controls.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      state     <= ST_ACTIVE;
      wake_pend <= 1'b0;
      clk_en_q  <= 1'b1;
      iso_q     <= 1'b0;
      ret_q     <= 1'b0;
      rstn_q    <= 1'b1;
      dcdc_q    <= 1'b1;
      status_q  <= 1'b1;
    end else begin
      // Sources only count outside ACTIVE; entry to ACTIVE clears below.
      if (state != ST_ACTIVE && wake_hit) begin
        wake_pend <= 1'b1;
      end
      case (state)
        ST_ACTIVE: begin
          if (bus.i_sleep_req) begin
            clk_en_q <= 1'b0;
            status_q <= 1'b0;
            state    <= bus.i_pwrgate_en ? ST_OFF_CLK : ST_CG_SLEEP;
          end
        end
        ST_CG_SLEEP: begin
          if (wake_pend) begin
            clk_en_q  <= 1'b1;
            status_q  <= 1'b1;
            wake_pend <= 1'b0;
            state     <= ST_ACTIVE;
          end
        end
        ST_OFF_CLK: if (tmr_done) begin iso_q  <= 1'b1; state <= ST_OFF_ISO; end
        ST_OFF_ISO: if (tmr_done) begin ret_q  <= 1'b1; state <= ST_OFF_RET; end
        ST_OFF_RET: if (tmr_done) begin rstn_q <= 1'b0; state <= ST_OFF_RST; end
        ST_OFF_RST: if (tmr_done) begin dcdc_q <= 1'b0; state <= ST_OFF;     end
        ST_OFF:     if (wake_pend) begin dcdc_q <= 1'b1; state <= ST_ON_DCDC; end
        ST_ON_DCDC: if (tmr_done) begin rstn_q <= 1'b1; state <= ST_ON_RST;  end
        ST_ON_RST:  if (tmr_done) begin ret_q  <= 1'b0; state <= ST_ON_RET;  end
        ST_ON_RET:  if (tmr_done) begin iso_q  <= 1'b0; state <= ST_ON_ISO;  end
        ST_ON_ISO: begin
          if (tmr_done) begin
            clk_en_q  <= 1'b1;
            status_q  <= 1'b1;
            wake_pend <= 1'b0;
            state     <= ST_ACTIVE;
          end
        end
        default: state <= ST_ACTIVE;
      endcase
    end
  end

  assign bus.o_clk_en      = clk_en_q;
  assign bus.o_iso         = iso_q;
  assign bus.o_ret         = ret_q;
  assign bus.o_rstn        = rstn_q;
  assign bus.o_dcdc_enable = dcdc_q;
  assign bus.o_d_status    = status_q;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_pd_pwr_seq_fsm.sv
// Directed bench for pd_pwr_seq_fsm: output edge cycles are compared
// against hand-computed sequence timings.
module tb_pd_pwr_seq_fsm;
  import pwr_ctrl_pkg::*;

  localparam int B_CLK  = 0;
  localparam int B_ISO  = 1;
  localparam int B_RET  = 2;
  localparam int B_RSTN = 3;
  localparam int B_DCDC = 4;
  localparam int B_STAT = 5;
  localparam logic [5:0] ACTIVE_OUTS = 6'b111001;  // {status,dcdc,rstn,ret,iso,clk_en}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [5:0] out_hist [0:63];
  logic [3:0] st_hist  [0:63];

  pd_pwr_seq_fsm_if bus ();

  pd_pwr_seq_fsm dut (
    .i_aon_clk        (clk),
    .i_soc_pwr_on_rst (rst),
    .bus              (bus)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.o_d_status, bus.o_dcdc_enable, bus.o_rstn, bus.o_ret, bus.o_iso, bus.o_clk_en};
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive sleep/wake pulses at chosen cycles, record outputs for n cycles.
  // Cycle 0 is the current cycle; entry k is sampled #1 after the k-th edge.
  task automatic run_trace(input int n, input int sleep_cyc, input int wake_cyc,
                           input logic [2:0] wake_val);
    out_hist[0] = outs();
    st_hist[0]  = bus.dbg_state;
    for (int c = 0; c < n; c++) begin
      bus.i_sleep_req  = (c == sleep_cyc);
      bus.i_wakeup_src = (c == wake_cyc) ? wake_val : 3'b000;
      @(posedge clk);
      #1;
      out_hist[c+1] = outs();
      st_hist[c+1]  = bus.dbg_state;
    end
    bus.i_sleep_req  = 1'b0;
    bus.i_wakeup_src = 3'b000;
  endtask

  // First cycle after 'from' where output bit b changed, -1 if none.
  function automatic int next_edge(input int b, input int from, input int n);
    for (int c = from + 1; c <= n; c++) begin
      if (out_hist[c][b] != out_hist[c-1][b]) return c;
    end
    return -1;
  endfunction

  task automatic set_delays(input logic [3:0] on_seq, input logic [3:0] off_seq,
                            input logic [7:0] on_d, input logic [7:0] off_d);
    bus.i_pwr_on_seq_delay  = on_seq;
    bus.i_pwr_off_seq_delay = off_seq;
    bus.i_pwr_on_delay      = on_d;
    bus.i_pwr_off_delay     = off_d;
  endtask

  initial begin
    bus.i_sleep_req  = 1'b0;
    bus.i_wakeup_en  = 3'b000;
    bus.i_wakeup_src = 3'b000;
    bus.i_pwrgate_en = 1'b0;
    set_delays(4'd0, 4'd0, 8'd0, 8'd0);

    // Reset values, then idle with no request
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", int'(outs()), int'(ACTIVE_OUTS));
    check("rst_state", int'(bus.dbg_state), int'(ST_ACTIVE));
    rst = 1'b0;
    run_trace(6, -1, -1, 3'b000);
    check("idle_outs", int'(out_hist[6]), int'(ACTIVE_OUTS));
    check("idle_clk_edge", next_edge(B_CLK, 0, 6), -1);
    check("idle_dcdc_edge", next_edge(B_DCDC, 0, 6), -1);

    // Power-gate sleep: off_seq=2, off_delay=4
    bus.i_pwrgate_en = 1'b1;
    bus.i_wakeup_en  = 3'b001;
    set_delays(4'd1, 4'd2, 8'd3, 8'd4);
    run_trace(16, 0, -1, 3'b000);
    check("off_clk", next_edge(B_CLK, 0, 16), 1);
    check("off_stat", next_edge(B_STAT, 0, 16), 1);
    check("off_iso", next_edge(B_ISO, 0, 16), 3);
    check("off_ret", next_edge(B_RET, 0, 16), 5);
    check("off_rstn", next_edge(B_RSTN, 0, 16), 7);
    check("off_dcdc", next_edge(B_DCDC, 0, 16), 11);
    check("off_state", int'(st_hist[16]), int'(ST_OFF));

    // Wake from OFF: on_delay=3, on_seq=1, single-cycle source pulse
    run_trace(12, -1, 0, 3'b001);
    check("on_dcdc", next_edge(B_DCDC, 0, 12), 2);
    check("on_rstn", next_edge(B_RSTN, 0, 12), 5);
    check("on_ret", next_edge(B_RET, 0, 12), 6);
    check("on_iso", next_edge(B_ISO, 0, 12), 7);
    check("on_clk", next_edge(B_CLK, 0, 12), 8);
    check("on_stat", next_edge(B_STAT, 0, 12), 8);
    check("on_state", int'(st_hist[12]), int'(ST_ACTIVE));

    // Clock-gate sleep and enable gating of wake sources
    bus.i_pwrgate_en = 1'b0;
    run_trace(4, 0, -1, 3'b000);
    check("cg_clk", next_edge(B_CLK, 0, 4), 1);
    check("cg_stat", next_edge(B_STAT, 0, 4), 1);
    check("cg_iso", next_edge(B_ISO, 0, 4), -1);
    check("cg_dcdc", next_edge(B_DCDC, 0, 4), -1);
    check("cg_state", int'(st_hist[4]), int'(ST_CG_SLEEP));
    run_trace(5, -1, 0, 3'b010);
    check("cg_masked_clk", next_edge(B_CLK, 0, 5), -1);
    bus.i_wakeup_en = 3'b010;
    run_trace(5, -1, 0, 3'b010);
    check("cg_wake_clk", next_edge(B_CLK, 0, 5), 2);
    check("cg_wake_stat", next_edge(B_STAT, 0, 5), 2);

    // Wake pulse during OFF_ISO: off sequence completes, then ON_DCDC
    bus.i_pwrgate_en = 1'b1;
    bus.i_wakeup_en  = 3'b100;
    run_trace(22, 0, 3, 3'b100);
    check("mid_iso_state3", int'(st_hist[3]), int'(ST_OFF_ISO));
    check("mid_dcdc_off", next_edge(B_DCDC, 0, 22), 11);
    check("mid_state11", int'(st_hist[11]), int'(ST_OFF));
    check("mid_dcdc_on", next_edge(B_DCDC, 11, 22), 12);
    check("mid_state12", int'(st_hist[12]), int'(ST_ON_DCDC));
    check("mid_clk_on", next_edge(B_CLK, 1, 22), 18);

    // All delays zero: one cycle per step each way
    set_delays(4'd0, 4'd0, 8'd0, 8'd0);
    run_trace(8, 0, -1, 3'b000);
    check("z_off_iso", next_edge(B_ISO, 0, 8), 2);
    check("z_off_ret", next_edge(B_RET, 0, 8), 3);
    check("z_off_rstn", next_edge(B_RSTN, 0, 8), 4);
    check("z_off_dcdc", next_edge(B_DCDC, 0, 8), 5);
    run_trace(8, -1, 0, 3'b100);
    check("z_on_dcdc", next_edge(B_DCDC, 0, 8), 2);
    check("z_on_rstn", next_edge(B_RSTN, 0, 8), 3);
    check("z_on_ret", next_edge(B_RET, 0, 8), 4);
    check("z_on_iso", next_edge(B_ISO, 0, 8), 5);
    check("z_on_clk", next_edge(B_CLK, 0, 8), 6);

    // Reset asserted while in OFF_RET: immediate return to ACTIVE values
    run_trace(3, 0, -1, 3'b000);
    check("rst_mid_state", int'(st_hist[3]), int'(ST_OFF_RET));
    rst = 1'b1;
    #1;
    check("rst_mid_outs", int'(outs()), int'(ACTIVE_OUTS));
    check("rst_mid_st", int'(bus.dbg_state), int'(ST_ACTIVE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_trace(4, -1, -1, 3'b000);
    check("post_rst_outs", int'(out_hist[4]), int'(ACTIVE_OUTS));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pd_pwr_seq_fsm.md
# pd_pwr_seq_fsm

Per-domain power sequencing state machine in the always-on power controller. It consumes the control and timer fields of the AON register file: sleep request, wakeup enables, power-gating enable and sequence delays. It drives the domain's clock-enable, isolation, retention, reset and DC-DC enable, and returns the domain power status to the register file. One instance is built per power domain.

## Interface
- M, 3: number of wakeup sources for this domain
- i_aon_clk  in  1  always-on clock
- i_soc_pwr_on_rst  in  1  reset, asynchronous, active-high; clock i_aon_clk
- i_sleep_req  in  1  sleep request bit from register file
- i_wakeup_en  in  M  per-source wakeup enable
- i_wakeup_src  in  M  wakeup source levels
- i_pwrgate_en  in  1  1: full power-gate sleep, 0: clock-gate-only sleep
- i_pwr_on_seq_delay  in  4  dwell between power-on control steps
- i_pwr_off_seq_delay  in  4  dwell between power-off control steps
- i_pwr_on_delay  in  8  dwell after o_dcdc_enable rises
- i_pwr_off_delay  in  8  dwell before o_dcdc_enable falls
- o_clk_en  out  1  domain clock enable, active-high
- o_iso  out  1  isolation enable, active-high
- o_ret  out  1  retention enable, active-high
- o_rstn  out  1  domain reset, active-low
- o_dcdc_enable  out  1  domain supply enable
- o_d_status  out  1  1 = domain fully on (ACTIVE)

## Operation
- All outputs are registered. Reset puts the block in ACTIVE: o_clk_en=1, o_iso=0, o_ret=0, o_rstn=1, o_dcdc_enable=1, o_d_status=1. The wake-pending flag resets to 0.
- wake_pend is set when |(i_wakeup_src & i_wakeup_en) is high in any state other than ACTIVE. It is cleared on entry to ACTIVE. Sources are ignored while in ACTIVE.
- ACTIVE: if i_sleep_req=1, i_pwrgate_en is latched. Latched 0 -> CG_SLEEP. Latched 1 -> OFF_CLK.
- CG_SLEEP: o_clk_en=0, o_d_status=0. When wake_pend=1 -> ACTIVE, with o_clk_en=1 and o_d_status=1 on entry.
- Power-off path, with the output change on entry to each state:
  - OFF_CLK: o_clk_en=0, o_d_status=0.
  - OFF_ISO: o_iso=1.
  - OFF_RET: o_ret=1.
  - OFF_RST: o_rstn=0.
  - OFF: o_dcdc_enable=0.
  - Dwell in OFF_CLK, OFF_ISO and OFF_RET = off_seq_delay. Dwell in OFF_RST = off_delay.
- OFF: when wake_pend=1 -> ON_DCDC.
- Power-on path, with the output change on entry to each state:
  - ON_DCDC: o_dcdc_enable=1.
  - ON_RST: o_rstn=1.
  - ON_RET: o_ret=0.
  - ON_ISO: o_iso=0.
  - ACTIVE: o_clk_en=1, o_d_status=1.
  - Dwell in ON_DCDC = on_delay. Dwell in ON_RST, ON_RET and ON_ISO = on_seq_delay.
- A wakeup arriving during the off sequence is recorded in wake_pend. The off sequence still completes to OFF, and the FSM goes to ON_DCDC on the cycle after OFF is entered.
- i_sleep_req arriving during the on sequence is ignored until ACTIVE is reached.
- Reset mid-sequence returns the block immediately to ACTIVE reset values.

## Timing
- A dwell of D cycles means the next step's output changes D cycles after the current step's output changed. D=0 is treated as 1.
- The delay value is sampled into the timer on entry to each dwell state. Register writes during a dwell do not affect the running dwell.
- Sleep acceptance latency: i_sleep_req high at cycle 0 in ACTIVE -> o_clk_en low at cycle 1.
- Wake latency: wake_pend is registered, so a source high at cycle 0 in OFF gives o_dcdc_enable high at cycle 2.
- Timer arithmetic is unsigned. The 8-bit counter is used for every dwell, and 4-bit delays are zero-extended to 8 bits.

## Configuration
- PWR_SEQ_WAKE_SYNC_EN defined: i_wakeup_src passes through a 2-flop synchronizer on i_aon_clk before gating with i_wakeup_en. This adds 2 cycles of wake latency.
- PWR_SEQ_WAKE_SYNC_EN undefined: i_wakeup_src is used directly and must already be synchronous to i_aon_clk.

## Structure
- Package pwr_ctrl_pkg holds:
  - the state enum typedef pwr_seq_state_t;
  - the delay width constants SEQ_DLY_W=4 and DCDC_DLY_W=8.
- Sub-module seq_delay_timer is an 8-bit loadable down-counter.
  - Inputs: load, value.
  - Output: done.
  - done asserts max(value,1) cycles after load.

## Test plan
- Reset release -> all outputs at ACTIVE values, o_d_status=1, and they stay there with no request.
- i_pwrgate_en=1, off_seq_delay=2, off_delay=4, sleep at cycle 0 -> o_clk_en↓ at 1, o_iso↑ at 3, o_ret↑ at 5, o_rstn↓ at 7, o_dcdc_enable↓ at 11.
- From OFF, on_delay=3, on_seq_delay=1, enabled source pulsed one cycle at cycle 0 -> o_dcdc_enable↑ at 2, o_rstn↑ at 5, o_ret↓ at 6, o_iso↓ at 7, o_clk_en↑ and o_d_status↑ at 8.
- i_pwrgate_en=0, sleep -> only o_clk_en↓ and o_d_status↓. A source with its enable=0 -> no wake. The same source with enable=1 -> o_clk_en↑ two cycles later.
- Source pulse during OFF_ISO -> the off sequence completes to OFF, then ON_DCDC follows on the next cycle.
- All delays=0 -> every step is 1 cycle. Reset asserted mid-way in OFF_RET -> immediate return to ACTIVE values.
